// File: rtl/sqrt_arb_pkg.sv
// Shared types and helpers for the Sqrt-sharing round-robin arbiter.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Requester id width; a 1-bit id is kept even for tiny requester counts.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so ptr is at bit 0,
// pick the lowest set bit, then rotate the winner index back.
module rr_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  logic [N-1:0] rot;
  int           first_i;
  int           sum_i;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[(int'(ptr) + i) % N];
    end
  end

  always_comb begin
    first_i = 0;
    any     = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        first_i = i;
        any     = 1'b1;
      end
    end
  end

  always_comb begin
    sum_i = int'(ptr) + first_i;
    if (sum_i >= N) sum_i = sum_i - N;
    gnt_id = IDW'(sum_i);
    gnt    = '0;
    if (any) gnt[sum_i] = 1'b1;
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one Sqrt unit among N_REQ requesters, one transaction in flight:
// grant -> issue radicand -> wait for root -> return root to the requester.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BIT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_msg,
  input  logic [N_REQ-1:0]             req_val,
  output logic [N_REQ-1:0]             req_rdy,
  output logic [BIT_WIDTH-1:0]         resp_msg,
  output logic [N_REQ-1:0]             resp_val,
  input  logic [N_REQ-1:0]             resp_rdy,
  output logic [BIT_WIDTH-1:0]         sqrt_recv_msg,
  output logic                         sqrt_recv_val,
  input  logic                         sqrt_recv_rdy,
  input  logic [BIT_WIDTH-1:0]         sqrt_send_msg,
  input  logic                         sqrt_send_val,
  output logic                         sqrt_send_rdy,
  output logic                         busy,
  output logic [id_width(N_REQ)-1:0]   grant_id
);

  localparam int IDW = id_width(N_REQ);

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [BIT_WIDTH-1:0] rad_q, rad_d;
  logic [BIT_WIDTH-1:0] res_q, res_d;

  logic [N_REQ-1:0]     gnt;
  logic [IDW-1:0]       gnt_id;
  logic                 gnt_any;

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_rr (
    .req    (req_val),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      rad_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      rad_q   <= rad_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    rad_d   = rad_q;
    res_d   = res_q;
    req_rdy = '0;
    case (state_q)
      IDLE: begin
        // The winner always has req_val high, so any grant is a fire.
        if (reset) req_rdy = gnt;
        if (gnt_any) begin
          id_d    = gnt_id;
          rad_d   = req_msg[int'(gnt_id)*BIT_WIDTH +: BIT_WIDTH];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (sqrt_recv_rdy) state_d = WAIT;
      end
      WAIT: begin
        if (sqrt_send_val) begin
          res_d   = sqrt_send_msg;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_rdy[id_q]) begin
          ptr_d   = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_val = '0;
    if (state_q == RESP) resp_val[id_q] = 1'b1;
  end

  assign resp_msg      = res_q;
  assign sqrt_recv_msg = rad_q;
  assign sqrt_recv_val = (state_q == ISSUE);
  assign sqrt_send_rdy = (state_q == WAIT);
  assign busy          = (state_q != IDLE);
  assign grant_id      = id_q;

endmodule
